// File: rtl/cpu_bus_pkg.sv
// Shared types and encodings for the CPU-to-memory bus arbiter.
package cpu_bus_pkg;

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        DATA  = 2'd1,
        FETCH = 2'd2,
        DONE  = 2'd3
    } bus_state_t;

    localparam logic [1:0] DRW_NONE  = 2'b00;
    localparam logic [1:0] DRW_READ  = 2'b01;
    localparam logic [1:0] DRW_WRITE = 2'b10;

    // Both 10 and 11 request a store, so only the upper bit matters.
    function automatic logic is_write(input logic [1:0] drw);
        return drw[1];
    endfunction

endpackage

// File: rtl/cpu_bus_timer.sv
// Per-transfer wait counter. 'expired' is high during the last cycle a
// request may stay unacknowledged before the arbiter gives up on it.
module cpu_bus_timer #(
    parameter  int TIMEOUT = 255,
    localparam int W       = $clog2(TIMEOUT + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

    logic [W-1:0] count;

    assign expired = (count == LAST);

    // Count unacknowledged cycles; clear takes priority and the count saturates.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != LAST)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/cpu_bus_arbiter.sv
// Serialises the CPU fetch and data ports onto one req/ack memory bus and
// stalls the pipeline until both accesses of the current step have finished.
module cpu_bus_arbiter
    import cpu_bus_pkg::*;
#(
    parameter int          TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] iaddr,
    output logic [31:0] iin,
    input  logic [31:0] daddr,
    input  logic [31:0] dout,
    input  logic [1:0]  drw,
    output logic [31:0] din,
    output logic        cpu_stall,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    output logic        bus_err
);

    bus_state_t  state;
    logic [31:0] iaddr_q;
    logic [31:0] daddr_q;
    logic [31:0] dout_q;
    logic        we_q;

    logic        in_xfer;
    logic        timer_expired;
    logic        abort;

    // Everything the bus sees comes from the state and the values captured in
    // ARB, so the CPU may change its ports freely while stalled.
    assign in_xfer   = (state == DATA) || (state == FETCH);
    assign cpu_stall = (state != DONE);
    assign bus_req   = in_xfer;
    assign bus_we    = (state == DATA) && we_q;
    assign bus_addr  = (state == FETCH) ? iaddr_q : daddr_q;
    assign bus_wdata = dout_q;

    // An ack in the expiry cycle still counts as a normal completion.
    assign abort = in_xfer && !bus_ack && timer_expired;

    cpu_bus_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (!in_xfer || bus_ack || abort),
        .enable  (in_xfer && !bus_ack),
        .expired (timer_expired)
    );

    // Step sequencer: capture the CPU request, run the optional data access,
    // then the fetch, then release the pipeline for one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ARB;
            iaddr_q <= '0;
            daddr_q <= '0;
            dout_q  <= '0;
            we_q    <= 1'b0;
            iin     <= '0;
            din     <= '0;
            bus_err <= 1'b0;
        end else begin
            case (state)
                ARB: begin
                    iaddr_q <= iaddr;
                    daddr_q <= daddr;
                    dout_q  <= dout;
                    we_q    <= is_write(drw);
                    state   <= (drw != DRW_NONE) ? DATA : FETCH;
                end
                DATA: begin
                    if (bus_ack || abort) begin
                        if (!we_q) begin
                            din <= bus_ack ? bus_rdata : ERR_DATA;
                        end
                        if (abort) begin
                            bus_err <= 1'b1;
                        end
                        state <= FETCH;
                    end
                end
                FETCH: begin
                    if (bus_ack || abort) begin
                        iin <= bus_ack ? bus_rdata : ERR_DATA;
                        if (abort) begin
                            bus_err <= 1'b1;
                        end
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= ARB;
                end
                default: begin
                    state <= ARB;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// Scoreboard bench for cpu_bus_arbiter: each step pushes the expected bus
// transfers and end-of-step results; a negedge slave/monitor pops and checks.
`timescale 1ns/1ps
module tb_cpu_bus_arbiter;

    localparam int          TO  = 4;
    localparam logic [31:0] ERR = 32'hDEADBEEF;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        int          waits;
        logic [31:0] rdata;
        bit          never;
    } xfer_t;

    typedef struct {
        logic [31:0] iin;
        logic [31:0] din;
        logic        err;
        int          len;
    } res_t;

    typedef struct {
        logic [1:0]  drw;
        logic [31:0] iaddr;
        logic [31:0] daddr;
        logic [31:0] dout;
        int          d_waits;
        logic [31:0] d_rdata;
        bit          d_never;
        int          f_waits;
        logic [31:0] f_rdata;
        bit          f_never;
    } step_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] iaddr = '0;
    logic [31:0] daddr = '0;
    logic [31:0] dout = '0;
    logic [1:0]  drw = '0;
    logic [31:0] iin;
    logic [31:0] din;
    logic        cpu_stall;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata = '0;
    logic        bus_ack = 1'b0;
    logic        bus_err;

    xfer_t bus_q[$];
    res_t  res_q[$];

    int total = 0;
    int bad = 0;

    logic [31:0] iin_m = '0;
    logic [31:0] din_m = '0;
    logic        err_m = 1'b0;
    logic        force_ack = 1'b0;
    logic [31:0] force_rdata = '0;

    xfer_t cur;
    bit    cur_v = 0;
    int    wcnt = 0;
    int    cyc = 0;
    res_t  r;

    cpu_bus_arbiter #(
        .TIMEOUT  (TO),
        .ERR_DATA (ERR)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .iaddr     (iaddr),
        .iin       (iin),
        .daddr     (daddr),
        .dout      (dout),
        .drw       (drw),
        .din       (din),
        .cpu_stall (cpu_stall),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .bus_ack   (bus_ack),
        .bus_err   (bus_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got=%h want=%h", tag, got, want);
        end
    endtask

    function automatic step_t mk(input logic [1:0] d, input logic [31:0] ia, input logic [31:0] da,
                                 input logic [31:0] dd, input int dw, input logic [31:0] drd,
                                 input bit dn, input int fw, input logic [31:0] frd, input bit fn);
        step_t s;
        s.drw = d;      s.iaddr = ia;    s.daddr = da;   s.dout = dd;
        s.d_waits = dw; s.d_rdata = drd; s.d_never = dn;
        s.f_waits = fw; s.f_rdata = frd; s.f_never = fn;
        return s;
    endfunction

    // Drive one CPU step, record what the bus and the CPU should see, and
    // wait until the pipeline is released.
    task automatic applyStimulus(input step_t s);
        xfer_t x;
        res_t  e;
        int    len;
        int    n;
        drw = s.drw; iaddr = s.iaddr; daddr = s.daddr; dout = s.dout;
        len = 2;
        if (s.drw != 2'b00) begin
            x.addr = s.daddr; x.we = s.drw[1]; x.wdata = s.dout;
            x.waits = s.d_waits; x.rdata = s.d_rdata; x.never = s.d_never;
            bus_q.push_back(x);
            len += s.d_never ? TO : s.d_waits + 1;
            if (s.d_never) err_m = 1'b1;
            if (!s.drw[1]) din_m = s.d_never ? ERR : s.d_rdata;
        end
        x.addr = s.iaddr; x.we = 1'b0; x.wdata = '0;
        x.waits = s.f_waits; x.rdata = s.f_rdata; x.never = s.f_never;
        bus_q.push_back(x);
        len += s.f_never ? TO : s.f_waits + 1;
        if (s.f_never) err_m = 1'b1;
        iin_m = s.f_never ? ERR : s.f_rdata;
        e.iin = iin_m; e.din = din_m; e.err = err_m; e.len = len;
        res_q.push_back(e);

        n = 0;
        do begin @(negedge clk); n++; end while (!bus_req && n < 50);
        checkOutput("req_wait", 32'(bus_req), 32'd1);
        force_ack = 1'b0;
        drw = 2'($urandom); iaddr = $urandom; daddr = $urandom; dout = $urandom;
        n = 0;
        while (cpu_stall && n < 100) begin @(negedge clk); n++; end
        checkOutput("done_wait", 32'(cpu_stall), 32'd0);
    endtask

    // Bus slave plus result monitor: answers requests from the queue and
    // checks each finished step on the single unstalled cycle.
    always @(negedge clk) begin
        if (!rst) begin
            cur_v = 0; cyc = 0;
            bus_ack = force_ack; bus_rdata = force_rdata;
            bus_q.delete(); res_q.delete();
        end else begin
            cyc++;
            if (bus_req) begin
                if (!cur_v) begin
                    if (bus_q.size() == 0) begin
                        checkOutput("spurious_req", 32'(bus_req), 32'd0);
                        cur.addr = '0; cur.we = 1'b0; cur.wdata = '0;
                        cur.waits = 0; cur.rdata = '0; cur.never = 0;
                    end else begin
                        cur = bus_q.pop_front();
                    end
                    cur_v = 1; wcnt = 0;
                end
                checkOutput("bus_addr", bus_addr, cur.addr);
                checkOutput("bus_we", 32'(bus_we), 32'(cur.we));
                checkOutput("stall_in_req", 32'(cpu_stall), 32'd1);
                if (cur.we) checkOutput("bus_wdata", bus_wdata, cur.wdata);
                if (!cur.never && wcnt == cur.waits) begin
                    bus_ack = 1'b1; bus_rdata = cur.rdata; cur_v = 0;
                end else begin
                    bus_ack = 1'b0; bus_rdata = $urandom;
                    if (cur.never && wcnt == TO - 1) cur_v = 0;
                    wcnt++;
                end
            end else begin
                bus_ack = force_ack; bus_rdata = force_rdata; cur_v = 0;
            end
            if (!cpu_stall) begin
                checkOutput("done_req_low", 32'(bus_req), 32'd0);
                if (res_q.size() == 0) begin
                    checkOutput("spurious_done", 32'(cpu_stall), 32'd1);
                end else begin
                    r = res_q.pop_front();
                    checkOutput("iin", iin, r.iin);
                    checkOutput("din", din, r.din);
                    checkOutput("bus_err", 32'(bus_err), 32'(r.err));
                    checkOutput("step_len", 32'(cyc), 32'(r.len));
                end
                cyc = 0;
            end
        end
    end

    // Main sequence.
    initial begin
        int n;
        xfer_t x;
        #12;
        checkOutput("rst_stall", 32'(cpu_stall), 32'd1);
        checkOutput("rst_req", 32'(bus_req), 32'd0);
        checkOutput("rst_we", 32'(bus_we), 32'd0);
        checkOutput("rst_err", 32'(bus_err), 32'd0);
        checkOutput("rst_iin", iin, 32'd0);
        checkOutput("rst_din", din, 32'd0);
        checkOutput("rst_addr", bus_addr, 32'd0);
        @(posedge clk); #1 rst = 1'b1;

        applyStimulus(mk(2'b00, 32'h100, 0, 0, 0, 0, 0, 0, 32'h3C011234, 0));
        applyStimulus(mk(2'b00, 32'h104, 0, 0, 0, 0, 0, 0, 32'h3C011235, 0));
        applyStimulus(mk(2'b00, 32'h108, 0, 0, 0, 0, 0, 0, 32'h3C011236, 0));
        applyStimulus(mk(2'b01, 32'h104, 32'h10000004, 0, 2, 32'hCAFEF00D, 0, 0, 32'h8C220000, 0));
        applyStimulus(mk(2'b10, 32'h108, 32'hF0200000, 32'hAA, 0, 32'h11111111, 0, 0, 32'h24420001, 0));
        applyStimulus(mk(2'b11, 32'h10C, 32'hF0200004, 32'h55, 1, 32'h22222222, 0, 1, 32'h24420002, 0));
        applyStimulus(mk(2'b00, 32'h110, 0, 0, 0, 0, 0, 3, 32'h12345678, 0));
        applyStimulus(mk(2'b00, 32'h114, 0, 0, 0, 0, 0, 0, 32'h0, 1));
        applyStimulus(mk(2'b01, 32'h118, 32'h10000008, 0, 0, 32'h0, 1, 0, 32'h00001111, 0));
        applyStimulus(mk(2'b10, 32'h11C, 32'hF0200008, 32'h77, 0, 32'h0, 1, 1, 32'h00002222, 0));
        applyStimulus(mk(2'b01, 32'h120, 32'h1000000C, 0, 1, 32'hA5A5A5A5, 0, 0, 32'h00003333, 0));
        for (int i = 0; i < 6; i++) begin
            applyStimulus(mk(2'($urandom_range(0, 3)), $urandom, $urandom, $urandom,
                             int'($urandom_range(0, 2)), $urandom, 0,
                             int'($urandom_range(0, 2)), $urandom, 0));
        end

        // Abort a data transfer with reset while the request is outstanding.
        drw = 2'b01; daddr = 32'h20000000; iaddr = 32'h200;
        x.addr = 32'h20000000; x.we = 1'b0; x.wdata = '0; x.waits = 100; x.rdata = '0; x.never = 0;
        bus_q.push_back(x);
        n = 0;
        do begin @(negedge clk); n++; end while (!bus_req && n < 50);
        checkOutput("mid_req", 32'(bus_req), 32'd1);
        @(negedge clk); #2 rst = 1'b0;
        #1;
        checkOutput("async_req", 32'(bus_req), 32'd0);
        checkOutput("async_stall", 32'(cpu_stall), 32'd1);
        checkOutput("async_err", 32'(bus_err), 32'd0);
        checkOutput("async_din", din, 32'd0);
        checkOutput("async_iin", iin, 32'd0);
        iin_m = '0; din_m = '0; err_m = 1'b0;
        force_ack = 1'b1; force_rdata = 32'h55555555;
        repeat (2) @(negedge clk);
        @(posedge clk); #1 rst = 1'b1;
        applyStimulus(mk(2'b00, 32'h300, 0, 0, 0, 0, 0, 1, 32'h0BADF00D, 0));
        applyStimulus(mk(2'b01, 32'h304, 32'h10000010, 0, 0, 32'h77778888, 0, 0, 32'h0000AAAA, 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard stop in case the sequence itself wedges.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got=running want=finished");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
